// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with stall/flush, writeback mux, sticky halt and
// a saturating retired-instruction counter.
module mem_wb_stage #(
  parameter int DW = 16,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mem_valid,
  input  logic [DW-1:0] mem_out,
  input  logic [DW-1:0] aluout,
  input  logic [DW-1:0] pc_plus2,
  input  logic          memtoreg,
  input  logic          pcs_sel,
  input  logic          regwrite,
  input  logic [RW-1:0] dstreg,
  input  logic          halt_in,
  input  logic          stall,
  input  logic          flush,
  output logic [DW-1:0] wb_data,
  output logic [RW-1:0] wb_reg,
  output logic          wb_en,
  output logic          halt,
  output logic [15:0]   retired
);

  typedef struct packed {
    logic          valid;
    logic [DW-1:0] data;
    logic [RW-1:0] rd;
    logic          regwrite;
    logic          halt;
  } wb_pipe_t;

  wb_pipe_t        q;
  logic [DW-1:0]   sel_data;

  // Writeback value is chosen ahead of the register; PCS outranks a load.
  always_comb begin
    sel_data = aluout;
    if (pcs_sel)       sel_data = pc_plus2;
    else if (memtoreg) sel_data = mem_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= '0;
      retired <= '0;
    end else if (!halt) begin
      if (flush) begin
        q <= '0;
      end else if (!stall) begin
        q <= '{valid: mem_valid, data: sel_data, rd: dstreg,
               regwrite: regwrite, halt: halt_in};
        if (mem_valid && retired != 16'hFFFF)
          retired <= retired + 16'd1;
      end
    end
  end

  // Once a valid HLT is captured the register freezes, so this stays set until rst.
  assign halt    = q.valid & q.halt;
  assign wb_data = q.data;
  assign wb_reg  = q.rd;
  assign wb_en   = q.valid & q.regwrite & (q.rd != '0) & ~halt;

endmodule
